// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter that shares one single-port sprite ROM between NUM_REQ pixel requesters.
// Converts (x, y) to a row-major ROM address and returns the tagged palette index two cycles after ack.
module sprite_rom_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int SPR_W   = 60,
  parameter int SPR_H   = 60,
  parameter int COORD_W = 6,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 5,
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*COORD_W-1:0] req_x,
  input  logic [NUM_REQ*COORD_W-1:0] req_y,
  output logic [NUM_REQ-1:0]         ack,
  output logic [ADDR_W-1:0]          rom_addr,
  input  logic [DATA_W-1:0]          rom_data,
  output logic                       rsp_valid,
  output logic [ID_W-1:0]            rsp_id,
  output logic [DATA_W-1:0]          rsp_data,
  output logic                       rsp_oob,
  output logic                       busy
);

  localparam int PW = COORD_W + ADDR_W;

  logic [ID_W-1:0]    ptr;
  logic [NUM_REQ-1:0] req_m;
  logic               grant;
  logic [ID_W-1:0]    grant_id;
  logic [ID_W-1:0]    cand;
  logic [COORD_W-1:0] sel_x;
  logic [COORD_W-1:0] sel_y;
  logic [PW-1:0]      addr_full;
  logic               sel_oob;

  logic               s1_valid;
  logic [ID_W-1:0]    s1_id;
  logic               s1_oob;
  logic               s2_valid;
  logic [ID_W-1:0]    s2_id;
  logic               s2_oob;

  // Requests are masked during reset so no ack can leak out while state is being cleared.
  assign req_m = rst ? '0 : req;

  always_comb begin
    ack      = '0;
    grant    = 1'b0;
    grant_id = '0;
    cand     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (!grant && req_m[cand]) begin
        grant    = 1'b1;
        grant_id = cand;
      end
    end
    if (grant) ack[grant_id] = 1'b1;
  end

  assign sel_x     = req_x[int'(grant_id)*COORD_W +: COORD_W];
  assign sel_y     = req_y[int'(grant_id)*COORD_W +: COORD_W];
  assign addr_full = PW'(sel_y) * PW'(SPR_W) + PW'(sel_x);
  assign sel_oob   = ({1'b0, sel_x} >= (COORD_W+1)'(SPR_W)) ||
                     ({1'b0, sel_y} >= (COORD_W+1)'(SPR_H));

  // Pointer advance plus stage 1 (address) and stage 2 (aligned with the ROM's registered read).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr      <= '0;
      rom_addr <= '0;
      s1_valid <= 1'b0;
      s1_id    <= '0;
      s1_oob   <= 1'b0;
      s2_valid <= 1'b0;
      s2_id    <= '0;
      s2_oob   <= 1'b0;
    end else begin
      s1_valid <= grant;
      if (grant) begin
        ptr      <= (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
        rom_addr <= sel_oob ? '0 : addr_full[ADDR_W-1:0];
        s1_id    <= grant_id;
        s1_oob   <= sel_oob;
      end
      s2_valid <= s1_valid;
      s2_id    <= s1_id;
      s2_oob   <= s1_oob;
    end
  end

  assign rsp_valid = s2_valid;
  assign rsp_id    = s2_id;
  assign rsp_oob   = s2_oob;
  assign rsp_data  = s2_oob ? '0 : rom_data;
  assign busy      = s1_valid | s2_valid;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Scoreboard bench for sprite_rom_arbiter with a behavioural registered ROM.
// Directed vectors carry hand-computed ack, id, address and oob; a monitor checks responses.
module tb_sprite_rom_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [23:0] req_x;
  logic [23:0] req_y;
  logic [3:0]  ack;
  logic [11:0] rom_addr;
  logic [4:0]  rom_data;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [4:0]  rsp_data;
  logic        rsp_oob;
  logic        busy;

  int assertions = 0;
  int failures   = 0;
  int cyc        = 0;

  typedef struct {
    int         due;
    logic [1:0] id;
    logic       oob;
    logic [4:0] data;
  } rsp_t;

  typedef struct {
    int          due;
    logic [11:0] addr;
  } addr_t;

  rsp_t  sb[$];
  addr_t aq[$];

  sprite_rom_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .req_x(req_x), .req_y(req_y), .ack(ack),
    .rom_addr(rom_addr), .rom_data(rom_data), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_oob(rsp_oob), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Sprite ROM contents: nonzero at address 0 so oob masking is observable.
  function automatic logic [4:0] romWord(input logic [11:0] a);
    logic [11:0] t;
    t = a ^ (a >> 5) ^ 12'h015;
    return t[4:0];
  endfunction

  always @(posedge clk) rom_data <= romWord(rom_addr);

  function automatic logic [23:0] pack4(input logic [5:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One cycle of stimulus: drive after the edge, check ack mid-cycle, queue the expected results.
  task automatic applyStimulus(input logic [3:0] r, input logic [23:0] xs, input logic [23:0] ys,
                               input logic [3:0] exp_ack, input logic [1:0] exp_id,
                               input logic [11:0] exp_addr, input logic exp_oob, input bit track);
    rsp_t  e;
    addr_t a;
    @(posedge clk);
    #1;
    req   = r;
    req_x = xs;
    req_y = ys;
    @(negedge clk);
    checkOutput("ack", 32'(ack), 32'(exp_ack));
    if (exp_ack != 4'b0 && track) begin
      e.due  = cyc + 2;
      e.id   = exp_id;
      e.oob  = exp_oob;
      e.data = exp_oob ? 5'd0 : romWord(exp_addr);
      sb.push_back(e);
      a.due  = cyc + 1;
      a.addr = exp_addr;
      aq.push_back(a);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(4'b0, 24'b0, 24'b0, 4'b0, 2'd0, 12'd0, 1'b0, 1'b0);
  endtask

  // Monitor: compares the registered address and every presented response against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (aq.size() > 0 && aq[0].due <= cyc) begin
        checkOutput("rom_addr", 32'(rom_addr), 32'(aq[0].addr));
        void'(aq.pop_front());
      end
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_rsp_valid", 32'(rsp_valid), 32'd0);
        end else begin
          checkOutput("rsp_latency", 32'(cyc), 32'(sb[0].due));
          checkOutput("rsp_id", 32'(rsp_id), 32'(sb[0].id));
          checkOutput("rsp_oob", 32'(rsp_oob), 32'(sb[0].oob));
          checkOutput("rsp_data", 32'(rsp_data), 32'(sb[0].data));
          void'(sb.pop_front());
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        checkOutput("missing_rsp_valid", 32'(rsp_valid), 32'd1);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    rst   = 1'b1;
    req   = 4'hF;
    req_x = 24'b0;
    req_y = 24'b0;
    @(negedge clk);
    checkOutput("reset_ack", 32'(ack), 32'd0);
    checkOutput("reset_rom_addr", 32'(rom_addr), 32'd0);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_rsp_id", 32'(rsp_id), 32'd0);
    checkOutput("reset_rsp_oob", 32'(rsp_oob), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    req = 4'b0;

    // Single request (3,2) -> address 123; pointer moves to 1.
    applyStimulus(4'b0001, pack4(3, 0, 0, 0), pack4(2, 0, 0, 0), 4'b0001, 2'd0, 12'd123, 1'b0, 1'b1);
    idle(1);
    checkOutput("busy_in_flight", 32'(busy), 32'd1);
    idle(2);
    checkOutput("busy_drained", 32'(busy), 32'd0);

    // Corner pixel (59,59) from requester 3 -> 3599; pointer wraps to 0.
    applyStimulus(4'b1000, pack4(0, 0, 0, 59), pack4(0, 0, 0, 59), 4'b1000, 2'd3, 12'd3599, 1'b0, 1'b1);

    // All four requesting: strict rotation, one response per cycle.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(4'b1111, pack4(0, 1, 2, 3), pack4(0, 1, 2, 3), 4'(1 << (i % 4)), 2'(i % 4),
                    12'((i % 4) * 61), 1'b0, 1'b1);
    end

    // Out-of-bounds coordinates: x=60, y=63, y=60.
    applyStimulus(4'b0001, pack4(60, 0, 0, 0), pack4(0, 0, 0, 0), 4'b0001, 2'd0, 12'd0, 1'b1, 1'b1);
    applyStimulus(4'b0010, pack4(0, 0, 0, 0), pack4(0, 63, 0, 0), 4'b0010, 2'd1, 12'd0, 1'b1, 1'b1);
    applyStimulus(4'b0100, pack4(0, 0, 0, 0), pack4(0, 0, 60, 0), 4'b0100, 2'd2, 12'd0, 1'b1, 1'b1);

    // Fairness after idle: grant to 2 leaves pointer at 3, so 0101 serves 0 before 2.
    applyStimulus(4'b0100, pack4(0, 0, 1, 0), pack4(0, 0, 1, 0), 4'b0100, 2'd2, 12'd61, 1'b0, 1'b1);
    idle(3);
    applyStimulus(4'b0101, pack4(5, 0, 2, 0), pack4(0, 0, 1, 0), 4'b0001, 2'd0, 12'd5, 1'b0, 1'b1);
    applyStimulus(4'b0101, pack4(5, 0, 2, 0), pack4(0, 0, 1, 0), 4'b0100, 2'd2, 12'd62, 1'b0, 1'b1);

    // A held request is a new request every cycle.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b0010, pack4(0, 10, 0, 0), pack4(0, 10, 0, 0), 4'b0010, 2'd1, 12'd610, 1'b0, 1'b1);
    end
    idle(3);

    // Reset in flight: the granted read is dropped and arbitration restarts at requester 0.
    applyStimulus(4'b0100, pack4(0, 0, 0, 0), pack4(0, 0, 1, 0), 4'b0100, 2'd2, 12'd60, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    req = 4'hF;
    @(negedge clk);
    checkOutput("busy_during_reset", 32'(busy), 32'd0);
    checkOutput("ack_during_reset", 32'(ack), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    req = 4'b0;
    @(negedge clk);
    checkOutput("dropped_rsp_valid", 32'(rsp_valid), 32'd0);
    applyStimulus(4'b1010, pack4(0, 2, 0, 3), pack4(0, 0, 0, 0), 4'b0010, 2'd1, 12'd2, 1'b0, 1'b1);
    idle(4);

    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
    checkOutput("addr_queue_empty", 32'(aq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
